mutex_buffer_sched: RTL and testbench

MUTEX_BUFFER_SCHED -- requirements
Module: mutex_buffer_sched

---
 rtl/mutex_buffer_sched_pkg.sv | 15 +
 rtl/mutex_buffer_sched_chan.sv | 102 ++++++++++
 rtl/mutex_buffer_sched.sv | 93 +++++++++
 tb/tb_mutex_buffer_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mutex_buffer_sched_pkg.sv
// Shared types and channel indices for the three-channel frame scheduler.
package mutex_buffer_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  localparam int NUM_CH = 3;
  localparam int CH_W   = 0;
  localparam int CH_R0  = 1;
  localparam int CH_R1  = 2;

endpackage

// File: rtl/mutex_buffer_sched_chan.sv
// One scheduler channel: IDLE/LAUNCH/ACTIVE FSM, sof/ack pulses, frame counter.
// Optional per-channel watchdog when MUTEX_BUFFER_SCHED_WATCHDOG_EN is defined.
module mutex_buffer_sched_chan
  import mutex_buffer_sched_pkg::*;
#(
  parameter int C_FRMCNT_WIDTH  = 16,
  parameter int C_TIMEOUT_WIDTH = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       launch_i,
  input  logic                       done_i,
  input  logic [C_TIMEOUT_WIDTH-1:0] cfg_timeout_i,
  input  logic                       err_clr_i,
  output logic                       sof_o,
  output logic                       ack_o,
  output logic                       busy_o,
  output logic                       cmpl_o,
  output logic [C_FRMCNT_WIDTH-1:0]  frm_cnt_o,
  output logic                       wd_err_o
);

  state_e                    state_q, state_d;
  logic                      ack_q;
  logic [C_FRMCNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                      cmpl;
  logic                      wd_fire;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmpl    = 1'b0;
    case (state_q)
      IDLE:   if (launch_i) state_d = LAUNCH;
      LAUNCH: state_d = ACTIVE;
      ACTIVE: begin
        // A done on the timeout cycle is a normal completion.
        if (done_i) begin
          state_d = IDLE;
          cnt_d   = cnt_q + C_FRMCNT_WIDTH'(1);
          cmpl    = 1'b1;
        end else if (wd_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_q == LAUNCH);
      cnt_q   <= cnt_d;
    end
  end

  assign sof_o     = (state_q == LAUNCH);
  assign ack_o     = ack_q;
  assign busy_o    = (state_q != IDLE);
  assign cmpl_o    = cmpl;
  assign frm_cnt_o = cnt_q;

`ifdef MUTEX_BUFFER_SCHED_WATCHDOG_EN
  logic [C_TIMEOUT_WIDTH-1:0] wd_cnt_q, wd_cnt_d, wd_inc;
  logic                       wd_err_q, wd_err_d;

  assign wd_inc  = wd_cnt_q + C_TIMEOUT_WIDTH'(1);
  assign wd_fire = (state_q == ACTIVE) && (cfg_timeout_i != '0) && (wd_inc == cfg_timeout_i);

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    wd_err_d = wd_err_q;
    if (state_q == LAUNCH)      wd_cnt_d = '0;
    else if (state_q == ACTIVE) wd_cnt_d = wd_inc;
    if (wd_fire && !done_i) wd_err_d = 1'b1;
    else if (err_clr_i)     wd_err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end

  assign wd_err_o = wd_err_q;
`else
  logic unused_wd;
  assign unused_wd = ^{cfg_timeout_i, err_clr_i};
  assign wd_fire   = 1'b0;
  assign wd_err_o  = 1'b0;
`endif

endmodule

// File: rtl/mutex_buffer_sched.sv
// Writer/reader frame scheduler: three independent channels, readers gated on have_frame.
// Watchdog build selected by MUTEX_BUFFER_SCHED_WATCHDOG_EN.
module mutex_buffer_sched
  import mutex_buffer_sched_pkg::*;
#(
  parameter int C_FRMCNT_WIDTH  = 16,
  parameter int C_TIMEOUT_WIDTH = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       soft_en,
  input  logic                       w_req,
  input  logic                       r0_req,
  input  logic                       r1_req,
  input  logic                       w_done,
  input  logic                       r0_done,
  input  logic                       r1_done,
  output logic                       w_sof,
  output logic                       r0_sof,
  output logic                       r1_sof,
  output logic                       w_ack,
  output logic                       r0_ack,
  output logic                       r1_ack,
  output logic                       w_busy,
  output logic                       r0_busy,
  output logic                       r1_busy,
  output logic                       have_frame,
  output logic [C_FRMCNT_WIDTH-1:0]  w_frm_cnt,
  output logic [C_FRMCNT_WIDTH-1:0]  r0_frm_cnt,
  output logic [C_FRMCNT_WIDTH-1:0]  r1_frm_cnt,
  input  logic [C_TIMEOUT_WIDTH-1:0] cfg_timeout,
  input  logic                       err_clr,
  output logic [2:0]                 wd_err
);

  logic [NUM_CH-1:0]         req, done, elig, sof, ack, busy, cmpl;
  logic [C_FRMCNT_WIDTH-1:0] frm_cnt [NUM_CH];
  logic                      have_frame_q, have_frame_d;

  assign req[CH_W]   = w_req;
  assign req[CH_R0]  = r0_req;
  assign req[CH_R1]  = r1_req;
  assign done[CH_W]  = w_done;
  assign done[CH_R0] = r0_done;
  assign done[CH_R1] = r1_done;

  // Readers only see a registered have_frame, so they trail the first w_done by a cycle.
  assign elig[CH_W]  = 1'b1;
  assign elig[CH_R0] = have_frame_q;
  assign elig[CH_R1] = have_frame_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mutex_buffer_sched_chan #(
      .C_FRMCNT_WIDTH (C_FRMCNT_WIDTH),
      .C_TIMEOUT_WIDTH(C_TIMEOUT_WIDTH)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .launch_i     (req[c] & soft_en & elig[c]),
      .done_i       (done[c]),
      .cfg_timeout_i(cfg_timeout),
      .err_clr_i    (err_clr),
      .sof_o        (sof[c]),
      .ack_o        (ack[c]),
      .busy_o       (busy[c]),
      .cmpl_o       (cmpl[c]),
      .frm_cnt_o    (frm_cnt[c]),
      .wd_err_o     (wd_err[c])
    );
  end

  assign have_frame_d = have_frame_q | cmpl[CH_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) have_frame_q <= 1'b0;
    else       have_frame_q <= have_frame_d;
  end

  assign have_frame = have_frame_q;
  assign w_sof      = sof[CH_W];
  assign r0_sof     = sof[CH_R0];
  assign r1_sof     = sof[CH_R1];
  assign w_ack      = ack[CH_W];
  assign r0_ack     = ack[CH_R0];
  assign r1_ack     = ack[CH_R1];
  assign w_busy     = busy[CH_W];
  assign r0_busy    = busy[CH_R0];
  assign r1_busy    = busy[CH_R1];
  assign w_frm_cnt  = frm_cnt[CH_W];
  assign r0_frm_cnt = frm_cnt[CH_R0];
  assign r1_frm_cnt = frm_cnt[CH_R1];

endmodule

// File: tb/tb_mutex_buffer_sched.sv
// Directed bench for mutex_buffer_sched, built with a 4-bit frame counter.
module tb_mutex_buffer_sched;

  localparam int FW = 4;
  localparam int TW = 24;

  logic          clk, reset, soft_en;
  logic          w_req, r0_req, r1_req, w_done, r0_done, r1_done;
  logic          w_sof, r0_sof, r1_sof, w_ack, r0_ack, r1_ack;
  logic          w_busy, r0_busy, r1_busy, have_frame;
  logic [FW-1:0] w_frm_cnt, r0_frm_cnt, r1_frm_cnt;
  logic [TW-1:0] cfg_timeout;
  logic          err_clr;
  logic [2:0]    wd_err;

  int            n_chk = 0;
  int            n_err = 0;
  logic [FW-1:0] wexp, r0exp;

  mutex_buffer_sched #(.C_FRMCNT_WIDTH(FW), .C_TIMEOUT_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .soft_en(soft_en),
    .w_req(w_req), .r0_req(r0_req), .r1_req(r1_req),
    .w_done(w_done), .r0_done(r0_done), .r1_done(r1_done),
    .w_sof(w_sof), .r0_sof(r0_sof), .r1_sof(r1_sof),
    .w_ack(w_ack), .r0_ack(r0_ack), .r1_ack(r1_ack),
    .w_busy(w_busy), .r0_busy(r0_busy), .r1_busy(r1_busy),
    .have_frame(have_frame),
    .w_frm_cnt(w_frm_cnt), .r0_frm_cnt(r0_frm_cnt), .r1_frm_cnt(r1_frm_cnt),
    .cfg_timeout(cfg_timeout), .err_clr(err_clr), .wd_err(wd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic w_frame();
    w_req = 1'b1;
    step();
    chk1("w_sof_frame", w_sof, 1'b1);
    w_req = 1'b0;
    step();
    w_done = 1'b1;
    step();
    w_done = 1'b0;
    wexp   = wexp + 4'd1;
    chkv("w_cnt_frame", 32'(w_frm_cnt), 32'(wexp));
  endtask

  initial begin
    reset = 1'b1; soft_en = 1'b0;
    w_req = 1'b0; r0_req = 1'b0; r1_req = 1'b0;
    w_done = 1'b0; r0_done = 1'b0; r1_done = 1'b0;
    cfg_timeout = '0; err_clr = 1'b0;
    wexp = '0; r0exp = '0;

    // Reset state
    step(); step();
    chk1("rst_w_busy", w_busy, 1'b0);
    chk1("rst_r0_busy", r0_busy, 1'b0);
    chk1("rst_r1_busy", r1_busy, 1'b0);
    chk1("rst_w_sof", w_sof, 1'b0);
    chk1("rst_w_ack", w_ack, 1'b0);
    chk1("rst_have_frame", have_frame, 1'b0);
    chkv("rst_w_cnt", 32'(w_frm_cnt), 32'd0);
    chkv("rst_wd_err", 32'(wd_err), 32'd0);

    // Reader request without any writer frame never launches
    reset = 1'b0; soft_en = 1'b1; r0_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk1("r0_sof_no_frame", r0_sof, 1'b0);
    end
    chk1("have_frame_none", have_frame, 1'b0);

    // First writer frame, readers follow one cycle after have_frame
    r1_req = 1'b1; w_req = 1'b1;
    step();
    chk1("w_sof_c1", w_sof, 1'b1);
    chk1("w_ack_c1", w_ack, 1'b0);
    chk1("w_busy_c1", w_busy, 1'b1);
    w_req = 1'b0;
    step();
    chk1("w_sof_c2", w_sof, 1'b0);
    chk1("w_ack_c2", w_ack, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk1("w_ack_active", w_ack, 1'b0);
      chk1("w_busy_active", w_busy, 1'b1);
      chk1("r0_sof_wait", r0_sof, 1'b0);
    end
    w_done = 1'b1;
    step();
    w_done = 1'b0;
    wexp = 4'd1;
    chk1("w_busy_c11", w_busy, 1'b0);
    chkv("w_cnt_c11", 32'(w_frm_cnt), 32'd1);
    chk1("have_frame_c11", have_frame, 1'b1);
    chk1("r0_sof_c11", r0_sof, 1'b0);
    chk1("r1_sof_c11", r1_sof, 1'b0);
    step();
    chk1("r0_sof_c12", r0_sof, 1'b1);
    chk1("r1_sof_c12", r1_sof, 1'b1);
    chk1("w_sof_c12", w_sof, 1'b0);
    r0_req = 1'b0; r1_req = 1'b0;
    step();
    chk1("r0_ack_c13", r0_ack, 1'b1);
    chk1("r1_ack_c13", r1_ack, 1'b1);
    r0_done = 1'b1; r1_done = 1'b1;
    step();
    r0_done = 1'b0; r1_done = 1'b0;
    r0exp = 4'd1;
    chk1("r0_busy_done", r0_busy, 1'b0);
    chkv("r0_cnt_1", 32'(r0_frm_cnt), 32'd1);
    chkv("r1_cnt_1", 32'(r1_frm_cnt), 32'd1);

    // done while IDLE is ignored
    w_done = 1'b1;
    step();
    w_done = 1'b0;
    chkv("w_cnt_idle_done", 32'(w_frm_cnt), 32'(wexp));
    chk1("w_busy_idle_done", w_busy, 1'b0);

    // Writer and reader0 launching together, period 4
    w_req = 1'b1; r0_req = 1'b1;
    for (int it = 0; it < 3; it++) begin
      step();
      chk1("both_sof_w", w_sof, 1'b1);
      chk1("both_sof_r0", r0_sof, 1'b1);
      step();
      chk1("both_ack_w", w_ack, 1'b1);
      chk1("both_ack_r0", r0_ack, 1'b1);
      chk1("both_sof_gap", w_sof, 1'b0);
      step();
      chk1("both_busy", w_busy & r0_busy, 1'b1);
      w_done = 1'b1; r0_done = 1'b1;
      step();
      w_done = 1'b0; r0_done = 1'b0;
      wexp = wexp + 4'd1; r0exp = r0exp + 4'd1;
      chk1("both_idle_sof", w_sof | r0_sof, 1'b0);
      chkv("both_w_cnt", 32'(w_frm_cnt), 32'(wexp));
      chkv("both_r0_cnt", 32'(r0_frm_cnt), 32'(r0exp));
    end
    w_req = 1'b0; r0_req = 1'b0;
    step();
    chk1("both_release", w_sof | r0_sof, 1'b0);

    // done during LAUNCH ignored; minimum 3-cycle sof spacing
    w_req = 1'b1;
    step();
    chk1("min_sof_a", w_sof, 1'b1);
    w_done = 1'b1;
    step();
    chk1("min_ack", w_ack, 1'b1);
    chkv("min_cnt_launch_done", 32'(w_frm_cnt), 32'(wexp));
    step();
    wexp = wexp + 4'd1;
    chk1("min_idle", w_busy, 1'b0);
    chk1("min_idle_sof", w_sof, 1'b0);
    chkv("min_cnt", 32'(w_frm_cnt), 32'(wexp));
    w_done = 1'b0;
    step();
    chk1("min_sof_b", w_sof, 1'b1);
    w_req = 1'b0;
    step();
    w_done = 1'b1;
    step();
    w_done = 1'b0;
    wexp = wexp + 4'd1;
    chkv("min_cnt_b", 32'(w_frm_cnt), 32'(wexp));

    // Counter wrap at 4 bits (6 -> 15 -> 0 -> 2)
    for (int i = 0; i < 12; i++) w_frame();
    chkv("w_cnt_wrapped", 32'(w_frm_cnt), 32'd2);

    // soft_en low does not abort the running frame but blocks the next one
    w_req = 1'b1;
    step();
    chk1("se_sof", w_sof, 1'b1);
    soft_en = 1'b0;
    step();
    chk1("se_ack", w_ack, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("se_busy", w_busy, 1'b1);
    end
    w_done = 1'b1;
    step();
    w_done = 1'b0;
    wexp = wexp + 4'd1;
    chk1("se_done_idle", w_busy, 1'b0);
    chkv("se_cnt", 32'(w_frm_cnt), 32'(wexp));
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("se_blocked", w_sof, 1'b0);
    end
    soft_en = 1'b1;
    step();
    chk1("se_resume_sof", w_sof, 1'b1);
    w_req = 1'b0;
    step();
    chk1("pre_rst_ack", w_ack, 1'b1);

    // Asynchronous reset in ACTIVE
    reset = 1'b1;
    #1;
    chk1("arst_busy", w_busy, 1'b0);
    chk1("arst_ack", w_ack, 1'b0);
    chk1("arst_have_frame", have_frame, 1'b0);
    chkv("arst_cnt", 32'(w_frm_cnt), 32'd0);
    step();
    reset = 1'b0;
    wexp = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("post_rst_sof", w_sof, 1'b0);
      chk1("post_rst_ack", w_ack, 1'b0);
    end

    // Reader1 frame without done: watchdog or indefinite hold
    w_frame();
    chk1("wd_have_frame", have_frame, 1'b1);
    cfg_timeout = 24'd8;
    r1_req = 1'b1;
    step();
    chk1("wd_r1_sof", r1_sof, 1'b1);
    r1_req = 1'b0;
    step();
    chk1("wd_r1_ack", r1_ack, 1'b1);
`ifdef MUTEX_BUFFER_SCHED_WATCHDOG_EN
    for (int i = 0; i < 7; i++) begin
      step();
      chk1("wd_busy_hold", r1_busy, 1'b1);
      chkv("wd_err_quiet", 32'(wd_err), 32'd0);
    end
    step();
    chk1("wd_busy_fall", r1_busy, 1'b0);
    chkv("wd_err_set", 32'(wd_err), 32'd4);
    chkv("wd_r1_cnt", 32'(r1_frm_cnt), 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chkv("wd_err_clr", 32'(wd_err), 32'd0);
`else
    for (int i = 0; i < 10; i++) begin
      step();
      chk1("nowd_busy_hold", r1_busy, 1'b1);
      chkv("nowd_err", 32'(wd_err), 32'd0);
    end
    r1_done = 1'b1;
    step();
    r1_done = 1'b0;
    chk1("nowd_busy_fall", r1_busy, 1'b0);
    chkv("nowd_r1_cnt", 32'(r1_frm_cnt), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
